aska_ch_sched: RTL and testbench
================================

Name: aska_ch_sched

Overview:
- Round-robin channel scheduler that time-shares the single neurostimulation pulse generator (NPG) datapath among up to NCH electrode-pair configurations.
- Sits between the SPI configuration registers and the NPG electrode/enable inputs in the ASKA digital top.
- Holds one ele1/ele2 pattern pair per channel. Presents one pair at a time to the NPG, and advances to the next enabled channel only after each stimulation pulse completes.
- Electrode patterns never change while a pulse is in progress.

Parameters:
- NCH, 4: number of electrode channels (2..8).
- IDX_W, 2: channel index width; must equal clog2(NCH).
- GAP_CYC, 2: idle clk cycles between the end of a pulse and arming the next channel (1..15).
- TIMEOUT_CYC, 8192: WAIT_PULSE timeout in clk cycles. Used only with ASKA_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock (20 kHz internal clock)
- resetn  in  1  asynchronous reset, active-low
- cfg_we  in  1  write strobe; loads channel pattern registers
- cfg_addr  in  IDX_W  channel index for the write
- cfg_ele1  in  32  electrode-1 pattern for channel cfg_addr
- cfg_ele2  in  32  electrode-2 pattern for channel cfg_addr
- ch_mask  in  NCH  per-channel enable; bit i=1 means channel i participates
- sched_en  in  1  scheduler run request
- pulse_active  in  1  NPG pulse-in-progress flag; synchronous to clk
- ele1  out  32  electrode-1 pattern to the NPG
- ele2  out  32  electrode-2 pattern to the NPG
- npg_enable  out  1  NPG enable
- cur_ch  out  IDX_W  index of the channel currently presented
- busy  out  1  high whenever the state is not IDLE
- timeout_flag  out  1  sticky timeout fault (optional feature)

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - All channel registers, ele1, ele2 and cur_ch are cleared to 0. Zero patterns mean all H-bridge switches are open.
  - npg_enable=0, busy=0, timeout_flag=0.
  - Assertion mid-pulse aborts immediately.
- Config writes:
  - On a cfg_we clock edge, channel[cfg_addr] is loaded, any state.
  - ele1/ele2 outputs are separate registers. A write to the active channel takes effect only at that channel's next ARM.
  - cfg_addr values >= NCH are ignored.
- FSM states: IDLE, SELECT, ARM, WAIT_PULSE, WAIT_END, GAP.
- IDLE:
  - npg_enable=0; ele1/ele2 keep their last value.
  - Exit to SELECT when sched_en=1 and ch_mask!=0.
- SELECT (1 cycle):
  - Choose the next set bit of ch_mask after cur_ch, circularly, searching cur_ch+1 up to cur_ch+NCH.
  - The first selection after reset starts the search at index 0, which means channel 0 is chosen if it is enabled.
  - If only cur_ch is enabled, it is re-selected.
  - If ch_mask==0 in this cycle, go to IDLE.
- ARM (1 cycle):
  - Register cur_ch, then ele1/ele2 from channel[cur_ch].
  - npg_enable=1 from the next cycle.
  - Go to WAIT_PULSE.
- WAIT_PULSE:
  - npg_enable=1; wait for pulse_active=1, then go to WAIT_END.
  - If sched_en=0 or ch_mask[cur_ch]=0 while pulse_active=0: npg_enable=0, go to IDLE.
- WAIT_END:
  - Hold ele1, ele2, cur_ch and npg_enable stable.
  - On pulse_active=0, deassert npg_enable in the same transition, load the gap counter with GAP_CYC-1 and go to GAP.
  - sched_en or mask changes here are deferred; the pulse always finishes.
- GAP:
  - npg_enable=0; count down.
  - At 0: if sched_en=1, go to SELECT; else go to IDLE.
- Latency: from sched_en rise in IDLE to npg_enable=1 is 3 cycles (SELECT, ARM, output register).
- pulse_active already high on entry to WAIT_PULSE: go to WAIT_END next cycle. A leftover pulse is treated as this channel's pulse.
- Simultaneous cfg_we to channel k and SELECT choosing k: the new data is used, because the write and selection share an edge and ARM reads next cycle.

Optional Feature:
- Macro: ASKA_SCHED_TIMEOUT_EN.
- Defined:
  - A 14-bit counter runs in WAIT_PULSE.
  - If TIMEOUT_CYC cycles elapse without pulse_active=1: set timeout_flag (sticky until reset), npg_enable=0, go to GAP. The channel is skipped.
- Undefined:
  - No counter; WAIT_PULSE waits indefinitely.
  - timeout_flag is tied to 0.

Test Plan:
- Reset, then write ch0=0x1/0x2, ch2=0x4/0x8; ch_mask=4'b0101, sched_en=1 -> npg_enable=1 at cycle 3, cur_ch=0, ele1=0x1. After a pulse_active high/low, and GAP of 2 cycles, cur_ch=2, ele1=0x4.
- Rewrite ch2=0xFF while ch2 is in WAIT_END -> ele1 stays 0x4 until pulse end. The next ch2 ARM presents 0xFF.
- Drop sched_en during WAIT_END -> npg_enable stays 1 until pulse_active falls, then 0; after GAP, state IDLE, busy=0.
- ch_mask=4'b1000, three pulses -> cur_ch stays 3 every time; ch_mask=0 in IDLE -> never leaves IDLE.
- Assert resetn=0 mid-pulse -> ele1=ele2=0, npg_enable=0, busy=0 asynchronously, before the next edge.
- With ASKA_SCHED_TIMEOUT_EN, TIMEOUT_CYC=16, pulse_active held 0 -> after 16 cycles timeout_flag=1, the channel is skipped, and the flag stays 1 until reset.

Source files
------------

// File: rtl/aska_ch_sched.sv
// aska_ch_sched: round-robin scheduler sharing one NPG among NCH electrode-pair channels
// Optional WAIT_PULSE timeout with sticky fault flag enabled by ASKA_SCHED_TIMEOUT_EN.
module aska_ch_sched #(
    parameter int NCH         = 4,
    parameter int IDX_W       = 2,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             cfg_we_i,
    input  logic [IDX_W-1:0] cfg_addr_i,
    input  logic [31:0]      cfg_ele1_i,
    input  logic [31:0]      cfg_ele2_i,
    input  logic [NCH-1:0]   ch_mask_i,
    input  logic             sched_en_i,
    input  logic             pulse_active_i,
    output logic [31:0]      ele1_o,
    output logic [31:0]      ele2_o,
    output logic             npg_enable_o,
    output logic [IDX_W-1:0] cur_ch_o,
    output logic             busy_o,
    output logic             timeout_flag_o
);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ARM, S_WAIT_PULSE, S_WAIT_END, S_GAP} state_e;

    if (NCH < 2 || NCH > 8 || IDX_W != $clog2(NCH) || GAP_CYC < 1 || GAP_CYC > 15 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 16384) begin : g_bad_param
        $error("aska_ch_sched: parameter out of range");
    end

    state_e           state_q;
    logic [IDX_W-1:0] cur_ch_q;
    logic [31:0]      ele1_q;
    logic [31:0]      ele2_q;
    logic             en_q;
    logic [3:0]       gap_q;
    logic             first_q;
    logic [31:0]      ch_ele1_q [NCH];
    logic [31:0]      ch_ele2_q [NCH];
    logic [IDX_W-1:0] sel_d;
    logic [IDX_W-1:0] idx_d;
    logic             sel_ok_d;
    logic             to_hit_d;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            for (int c = 0; c < NCH; c++) begin
                ch_ele1_q[c] <= '0;
                ch_ele2_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_we_i && cfg_addr_i == IDX_W'(c)) begin
                    ch_ele1_q[c] <= cfg_ele1_i;
                    ch_ele2_q[c] <= cfg_ele2_i;
                end
            end
        end
    end

    // Walk offsets from far to near so the nearest enabled channel wins.
    always_comb begin
        sel_d    = '0;
        sel_ok_d = 1'b0;
        idx_d    = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx_d = first_q ? IDX_W'(k - 1) : IDX_W'((int'(cur_ch_q) + k) % NCH);
            if (ch_mask_i[idx_d]) begin
                sel_d    = idx_d;
                sel_ok_d = 1'b1;
            end
        end
    end

`ifdef ASKA_SCHED_TIMEOUT_EN
    logic [13:0] to_cnt_q;
    logic        to_flag_q;

    assign to_hit_d = state_q == S_WAIT_PULSE && !pulse_active_i && to_cnt_q == 14'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == S_WAIT_PULSE) ? to_cnt_q + 14'd1 : '0;
            if (to_hit_d) to_flag_q <= 1'b1;
        end
    end

    assign timeout_flag_o = to_flag_q;
`else
    assign to_hit_d       = 1'b0;
    assign timeout_flag_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= S_IDLE;
            cur_ch_q <= '0;
            ele1_q   <= '0;
            ele2_q   <= '0;
            en_q     <= 1'b0;
            gap_q    <= '0;
            first_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (sched_en_i && |ch_mask_i) state_q <= S_SELECT;
                S_SELECT: begin
                    if (sel_ok_d) begin
                        cur_ch_q <= sel_d;
                        first_q  <= 1'b0;
                        state_q  <= S_ARM;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ARM: begin
                    ele1_q  <= ch_ele1_q[cur_ch_q];
                    ele2_q  <= ch_ele2_q[cur_ch_q];
                    en_q    <= 1'b1;
                    state_q <= S_WAIT_PULSE;
                end
                S_WAIT_PULSE: begin
                    if (pulse_active_i) begin
                        state_q <= S_WAIT_END;
                    end else if (!sched_en_i || !ch_mask_i[cur_ch_q]) begin
                        en_q    <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (to_hit_d) begin
                        en_q    <= 1'b0;
                        gap_q   <= 4'(GAP_CYC - 1);
                        state_q <= S_GAP;
                    end
                end
                // Once the pulse has started it always runs to completion.
                S_WAIT_END: begin
                    if (!pulse_active_i) begin
                        en_q    <= 1'b0;
                        gap_q   <= 4'(GAP_CYC - 1);
                        state_q <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) state_q <= sched_en_i ? S_SELECT : S_IDLE;
                    else gap_q <= gap_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ele1_o       = ele1_q;
    assign ele2_o       = ele2_q;
    assign npg_enable_o = en_q;
    assign cur_ch_o     = cur_ch_q;
    assign busy_o       = state_q != S_IDLE;
endmodule

// File: tb/tb_aska_ch_sched.sv
// tb_aska_ch_sched: scoreboard bench; expected channel presentations are queued by the
// stimulus and checked by a monitor on each npg_enable rise and while the pulse is held.
module tb_aska_ch_sched;
    typedef struct {
        logic [1:0]  ch;
        logic [31:0] e1;
        logic [31:0] e2;
    } pres_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_ele1 = '0;
    logic [31:0] cfg_ele2 = '0;
    logic [3:0]  ch_mask = '0;
    logic        sched_en = 1'b0;
    logic        pulse_active = 1'b0;
    logic [31:0] ele1;
    logic [31:0] ele2;
    logic        npg_enable;
    logic [1:0]  cur_ch;
    logic        busy;
    logic        timeout_flag;

    pres_t exp_q[$];
    pres_t held;
    logic  prev_en = 1'b0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    n;

    aska_ch_sched #(.NCH(4), .IDX_W(2), .GAP_CYC(2), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk), .resetn_i(resetn), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
        .cfg_ele1_i(cfg_ele1), .cfg_ele2_i(cfg_ele2), .ch_mask_i(ch_mask),
        .sched_en_i(sched_en), .pulse_active_i(pulse_active), .ele1_o(ele1), .ele2_o(ele2),
        .npg_enable_o(npg_enable), .cur_ch_o(cur_ch), .busy_o(busy), .timeout_flag_o(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic [31:0] e1, input logic [31:0] e2);
        pres_t p;
        p.ch = ch;
        p.e1 = e1;
        p.e2 = e2;
        exp_q.push_back(p);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] e1, input logic [31:0] e2);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_ele1 = e1;
        cfg_ele2 = e2;
        tick(1);
        cfg_we = 1'b0;
    endtask

    // Cycles until npg_enable reaches v; an expired budget is a failure.
    task automatic count_until(input logic v, output int cnt);
        cnt = 0;
        do begin
            tick(1);
            cnt++;
        end while (npg_enable !== v && cnt < 100);
        if (npg_enable !== v) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_enable: npg_enable never reached %0b at %0t", v, $time);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick(2);
        resetn = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            prev_en = 1'b0;
        end else begin
            if (npg_enable && !prev_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_present", 32'(cur_ch), 32'hDEAD);
                end else begin
                    held = exp_q.pop_front();
                    chk("present_ch", 32'(cur_ch), 32'(held.ch));
                    chk("present_ele1", ele1, held.e1);
                    chk("present_ele2", ele2, held.e2);
                end
            end else if (npg_enable) begin
                chk("hold_ch", 32'(cur_ch), 32'(held.ch));
                chk("hold_ele1", ele1, held.e1);
                chk("hold_ele2", ele2, held.e2);
            end
            prev_en = npg_enable;
        end
    end

    initial begin
        tick(2);
        chk("rst_ele1", ele1, 0);
        chk("rst_en", 32'(npg_enable), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        chk("rst_flag", 32'(timeout_flag), 0);
        resetn = 1'b1;
        tick(1);

        // Basic round robin over channels 0 and 2
        wr(2'd0, 32'h1, 32'h2);
        wr(2'd2, 32'h4, 32'h8);
        push(2'd0, 32'h1, 32'h2);
        push(2'd2, 32'h4, 32'h8);
        ch_mask = 4'b0101;
        sched_en = 1'b1;
        count_until(1'b1, n);
        chk("start_latency", n, 3);
        chk("busy_running", 32'(busy), 1);
        pulse_active = 1'b1;
        tick(3);
        pulse_active = 1'b0;
        count_until(1'b1, n);
        chk("gap_latency", n, 5);

        // Rewrite of the active channel mid-pulse is deferred to its next ARM
        push(2'd0, 32'h1, 32'h2);
        push(2'd2, 32'hFF, 32'hEE);
        pulse_active = 1'b1;
        tick(2);
        wr(2'd2, 32'hFF, 32'hEE);
        tick(1);
        chk("ele1_held_mid_pulse", ele1, 32'h4);
        pulse_active = 1'b0;
        count_until(1'b1, n);
        pulse_active = 1'b1;
        tick(2);
        pulse_active = 1'b0;
        count_until(1'b1, n);

        // Dropping sched_en during WAIT_END lets the pulse finish
        pulse_active = 1'b1;
        tick(1);
        sched_en = 1'b0;
        tick(2);
        chk("en_hold_after_drop", 32'(npg_enable), 1);
        pulse_active = 1'b0;
        tick(1);
        chk("en_off_at_pulse_end", 32'(npg_enable), 0);
        chk("busy_in_gap", 32'(busy), 1);
        tick(2);
        chk("idle_after_gap", 32'(busy), 0);
        tick(5);
        chk("stays_off", 32'(npg_enable), 0);

        // Single enabled channel is re-selected each time
        wr(2'd3, 32'h30, 32'h31);
        ch_mask = 4'b1000;
        repeat (3) push(2'd3, 32'h30, 32'h31);
        sched_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            count_until(1'b1, n);
            pulse_active = 1'b1;
            tick(1);
            if (i == 2) sched_en = 1'b0;
            tick(1);
            pulse_active = 1'b0;
        end
        tick(4);
        chk("single_ch_idle", 32'(busy), 0);
        ch_mask = 4'b0000;
        sched_en = 1'b1;
        tick(10);
        chk("empty_mask_idle", 32'(busy), 0);
        sched_en = 1'b0;

        // Asynchronous reset mid-pulse
        ch_mask = 4'b0001;
        push(2'd0, 32'h1, 32'h2);
        sched_en = 1'b1;
        count_until(1'b1, n);
        pulse_active = 1'b1;
        tick(1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_ele1", ele1, 0);
        chk("arst_ele2", ele2, 0);
        chk("arst_en", 32'(npg_enable), 0);
        chk("arst_busy", 32'(busy), 0);
        pulse_active = 1'b0;
        sched_en = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(1);

        // Channel registers were cleared by reset
        push(2'd0, 32'h0, 32'h0);
        sched_en = 1'b1;
        count_until(1'b1, n);
        sched_en = 1'b0;
        tick(2);
        chk("abort_to_idle", 32'(busy), 0);

`ifdef ASKA_SCHED_TIMEOUT_EN
        do_reset();
        wr(2'd0, 32'h11, 32'h12);
        wr(2'd1, 32'h21, 32'h22);
        ch_mask = 4'b0011;
        push(2'd0, 32'h11, 32'h12);
        push(2'd1, 32'h21, 32'h22);
        sched_en = 1'b1;
        count_until(1'b1, n);
        count_until(1'b0, n);
        chk("timeout_cycles", n, 16);
        chk("timeout_set", 32'(timeout_flag), 1);
        count_until(1'b1, n);
        chk("skip_latency", n, 4);
        sched_en = 1'b0;
        tick(2);
        chk("timeout_sticky", 32'(timeout_flag), 1);
        chk("timeout_idle", 32'(busy), 0);
        do_reset();
        chk("timeout_cleared", 32'(timeout_flag), 0);
`else
        do_reset();
        wr(2'd0, 32'h11, 32'h12);
        ch_mask = 4'b0001;
        push(2'd0, 32'h11, 32'h12);
        sched_en = 1'b1;
        count_until(1'b1, n);
        tick(40);
        chk("wait_forever_en", 32'(npg_enable), 1);
        chk("no_timeout_flag", 32'(timeout_flag), 0);
        sched_en = 1'b0;
        tick(2);
`endif

        tick(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
